// File: rtl/packet_forwarder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : packet_forwarder
// Description : Drains a stored packet from the dual-word packet RAM read
//               port and emits it as a 32-bit AXI-Stream with tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic [DATA_WIDTH/2-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int          HALF       = DATA_WIDTH / 2;
    localparam logic [31:0] c_LAST_MAX = 32'((1 << ADDR_WIDTH) - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_HI   = 3'd2;
    localparam logic [2:0] c_LO   = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_q,  last_d;
    logic [ADDR_WIDTH-1:0] p_q,     p_d;
    logic [ADDR_WIDTH-1:0] w_p_plus1;
    logic [ADDR_WIDTH-1:0] w_p_plus2;

    assign w_p_plus1 = p_q + ADDR_WIDTH'(1);
    assign w_p_plus2 = p_q + ADDR_WIDTH'(2);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        p_d           = p_q;
        busy          = 1'b0;
        done          = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    last_d  = (len > c_LAST_MAX) ? c_LAST_MAX[ADDR_WIDTH-1:0]
                                                 : len[ADDR_WIDTH-1:0];
                    p_d     = '0;
                    state_d = c_RD;
                end
            end
            c_RD: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = p_q;
                state_d = c_HI;
            end
            c_HI: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rd_data[DATA_WIDTH-1:HALF];
                m_axis_tlast  = (p_q == last_q);
                if (m_axis_tready) begin
                    state_d = m_axis_tlast ? c_DONE : c_LO;
                end
            end
            c_LO: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rd_data[HALF-1:0];
                m_axis_tlast  = (w_p_plus1 == last_q);
                // Next pair is fetched on the handshake itself so HI sees it
                // one cycle later, keeping a word per cycle with no bubble.
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_d = c_DONE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = w_p_plus2;
                        p_d     = w_p_plus2;
                        state_d = c_HI;
                    end
                end
            end
            c_DONE: begin
                done    = 1'b1;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            last_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            p_q     <= p_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_forwarder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_packet_forwarder
// Description : Randomised self-checking bench for packet_forwarder against a
//               RAM model and an expected word-list reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_forwarder;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [DEPTH];

    packet_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    // Dual-word read port: word[A] high, word[A+1] low, output holds when idle.
    always @(posedge clk) begin
        if (rd_en) rd_data <= {mem[int'(rd_addr)], mem[(int'(rd_addr) + 1) % DEPTH]};
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? $urandom : 32'hA000_0000 + i;
    endtask

    // Issues one packet and compares the observed stream with the list of
    // words the reference expects: mem[0 .. min(len,DEPTH-1)].
    task automatic run_packet(input int len_in, input bit stall, input int exp_done,
                              input int start2_cycle, input int len2);
        int          n;
        logic [31:0] got_data[$];
        bit          got_last[$];
        int          reads, read_viol, hold_viol, busy_viol, idle_viol;
        int          done_cyc, first_rd, first_valid;
        logic        pv, pr, pl;
        logic [31:0] pd;

        n = (len_in > DEPTH - 1) ? DEPTH : len_in + 1;
        reads = 0; read_viol = 0; hold_viol = 0; busy_viol = 0; idle_viol = 0;
        done_cyc = -1; first_rd = -1; first_valid = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;

        @(negedge clk);
        start  = 1'b1;
        len    = len_in;
        tready = 1'b1;
        #1;
        check_val("idle_before_start", {busy, tvalid, done}, 0);

        for (int c = 1; c < 8000 && done_cyc < 0; c++) begin
            @(negedge clk);
            start  = (c == start2_cycle);
            len    = (c == start2_cycle) ? len2 : $urandom;
            tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) hold_viol++;
            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                if (rd_addr !== AW'(2 * reads)) read_viol++;
                if (tvalid && (!tready || tlast)) read_viol++;
                reads++;
            end
            if (tvalid && first_valid < 0) first_valid = c;
            if (tvalid && tready) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
            end
            if (done) begin
                done_cyc = c;
                if (busy || tvalid) busy_viol++;
            end else if (busy !== 1'b1) begin
                busy_viol++;
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
        end

        check_val("done_seen", done_cyc >= 0, 1);
        if (exp_done >= 0) check_val("done_cycle", done_cyc, exp_done);
        check_val("first_rd_cycle", first_rd, 1);
        check_val("first_valid_cycle", first_valid, 2);
        check_val("beat_count", got_data.size(), n);
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            check_val($sformatf("data[%0d]", i), got_data[i], mem[i]);
            check_val($sformatf("tlast[%0d]", i), got_last[i], i == n - 1);
        end
        check_val("read_count", reads, (n + 1) / 2);
        check_val("read_violations", read_viol, 0);
        check_val("stall_hold_violations", hold_viol, 0);
        check_val("busy_violations", busy_viol, 0);

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start  = 1'b0;
            tready = 1'b1;
            #1;
            if (busy || tvalid || done || rd_en) idle_viol++;
        end
        check_val("idle_after_done", idle_viol, 0);
    endtask

    task automatic reset_midway();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        start  = 1'b1;
        len    = 7;
        tready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (c == 4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_mid_busy",  busy,   0);
        check_val("rst_mid_done",  done,   0);
        check_val("rst_mid_rd_en", rd_en,  0);
        check_val("rst_mid_rdadr", rd_addr, 0);
        check_val("rst_mid_tvld",  tvalid, 0);
        check_val("rst_mid_tlast", tlast,  0);
        check_val("rst_mid_tdata", tdata,  0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || tvalid) done_seen++;
        end
        check_val("rst_mid_quiet", done_seen, 0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        len    = '0;
        tready = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_busy",    busy,    0);
        check_val("reset_done",    done,    0);
        check_val("reset_rd_en",   rd_en,   0);
        check_val("reset_rd_addr", rd_addr, 0);
        check_val("reset_tvalid",  tvalid,  0);
        check_val("reset_tlast",   tlast,   0);
        check_val("reset_tdata",   tdata,   0);
        @(negedge clk);
        rst = 1'b0;

        run_packet(5,    1'b0, 8,    -1, 0);
        run_packet(4,    1'b0, 7,    -1, 0);
        run_packet(0,    1'b0, 3,     3, 9);   // start during DONE is ignored
        run_packet(9,    1'b1, -1,   -1, 0);
        run_packet(2000, 1'b0, 1026, -1, 0);
        reset_midway();
        run_packet(1,    1'b0, 4,    -1, 0);
        run_packet(3,    1'b0, 6,     3, 9);   // start while busy is ignored

        fill_mem(1'b1);
        run_packet(1023, 1'b1, -1,   -1, 0);
        for (int t = 0; t < 6; t++) begin
            run_packet(int'($urandom_range(0, 40)), 1'b1, -1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
